gpr_file: RTL and testbench

Architectural general-purpose register file and commit point of the core. It accepts one retiring instruction per cycle from writeback through a valid/ready handshake and updates the GPRs and the next PC. It serves two combinational read ports to decode. It also presents a registered commit snapshot (flat GPR bus, npc, commit strobe) to the downstream difftest/DPI register-export stage, holding each commit until that stage accepts it.

---
 rtl/gpr_file.sv | 136 +++++++++++++
 tb/tb_gpr_file.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/gpr_file.sv
// gpr_file: architectural GPR file and commit point of the core.
// Accepts one retiring instruction per cycle from writeback, updates the
// GPRs and next PC, serves two combinational read ports with write-through
// bypass, and holds a registered commit snapshot until the difftest
// consumer accepts it.
module gpr_file #(
    parameter int          NR_REGS  = 16,
    parameter logic [31:0] RESET_PC = 32'h8000_0000,
    localparam int         AW       = $clog2(NR_REGS)
) (
    input  logic                  clk,
    input  logic                  resetn,
    input  logic [AW-1:0]         rs1_addr,
    output logic [31:0]           rs1_data,
    input  logic [AW-1:0]         rs2_addr,
    output logic [31:0]           rs2_data,
    input  logic                  wb_valid,
    output logic                  wb_ready,
    input  logic                  wb_wen,
    input  logic [AW-1:0]         wb_rd,
    input  logic [31:0]           wb_data,
    input  logic [31:0]           wb_npc,
    input  logic                  wb_halt,
    output logic [NR_REGS*32-1:0] gprs,
    output logic [31:0]           npc,
    output logic                  commit_valid,
    input  logic                  dt_ready,
    output logic [63:0]           commit_count,
    output logic                  halted
);

    localparam logic [0:0] ST_RUN  = 1'b0;
    localparam logic [0:0] ST_HALT = 1'b1;

    logic [31:0] regs_q [NR_REGS];
    logic [31:0] regs_d [NR_REGS];
    logic [31:0] npc_q, npc_d;
    logic [63:0] cnt_q, cnt_d;
    logic        cv_q, cv_d;
    logic [0:0]  state_q, state_d;
    logic        fire_s;

    // Accept a retire only while running and when the snapshot slot is free or being drained.
    always_comb begin
        wb_ready = 1'b0;
        case (state_q)
            ST_RUN:  wb_ready = !cv_q || dt_ready;
            ST_HALT: wb_ready = 1'b0;
            default: wb_ready = 1'b0;
        endcase
        fire_s = wb_valid && wb_ready;
    end

    // Next architectural state: register write (x0 dropped), npc, counter, snapshot strobe, halt.
    always_comb begin
        regs_d  = regs_q;
        npc_d   = npc_q;
        cnt_d   = cnt_q;
        cv_d    = cv_q;
        state_d = state_q;
        if (fire_s) begin
            if (wb_wen && (wb_rd != {AW{1'b0}})) begin
                regs_d[wb_rd] = wb_data;
            end else begin
                regs_d = regs_q;
            end
            npc_d = wb_npc;
            cnt_d = cnt_q + 64'd1;
            cv_d  = 1'b1;
            if (wb_halt) begin
                state_d = ST_HALT;
            end else begin
                state_d = state_q;
            end
        end else begin
            cv_d = cv_q && !dt_ready;
        end
    end

    // State registers with synchronous active-low reset; reset discards any pending snapshot.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            for (int i = 0; i < NR_REGS; i++) begin
                regs_q[i] <= 32'h0000_0000;
            end
            npc_q   <= RESET_PC;
            cnt_q   <= 64'd0;
            cv_q    <= 1'b0;
            state_q <= ST_RUN;
        end else begin
            for (int i = 0; i < NR_REGS; i++) begin
                regs_q[i] <= regs_d[i];
            end
            npc_q   <= npc_d;
            cnt_q   <= cnt_d;
            cv_q    <= cv_d;
            state_q <= state_d;
        end
    end

    // Read port 1: x0 reads zero, a same-cycle write to the address is bypassed.
    always_comb begin
        if (rs1_addr == {AW{1'b0}}) begin
            rs1_data = 32'h0000_0000;
        end else if (fire_s && wb_wen && (wb_rd == rs1_addr)) begin
            rs1_data = wb_data;
        end else begin
            rs1_data = regs_q[rs1_addr];
        end
    end

    // Read port 2: same rules as port 1.
    always_comb begin
        if (rs2_addr == {AW{1'b0}}) begin
            rs2_data = 32'h0000_0000;
        end else if (fire_s && wb_wen && (wb_rd == rs2_addr)) begin
            rs2_data = wb_data;
        end else begin
            rs2_data = regs_q[rs2_addr];
        end
    end

    // Flatten the register array into the commit snapshot bus.
    always_comb begin
        gprs = {(NR_REGS*32){1'b0}};
        for (int i = 0; i < NR_REGS; i++) begin
            gprs[32*i +: 32] = regs_q[i];
        end
    end

    assign npc          = npc_q;
    assign commit_count = cnt_q;
    assign commit_valid = cv_q;
    assign halted       = (state_q == ST_HALT);

endmodule

// File: tb/tb_gpr_file.sv
// tb_gpr_file: randomized and directed stimulus for gpr_file, checked every
// cycle against a behavioural architectural model, plus literal pin checks.
module tb_gpr_file;

    localparam int NR = 16;
    localparam int AW = 4;

    logic              clk = 1'b0;
    logic              resetn;
    logic [AW-1:0]     rs1_addr, rs2_addr, wb_rd;
    logic [31:0]       rs1_data, rs2_data, wb_data, wb_npc, npc;
    logic              wb_valid, wb_ready, wb_wen, wb_halt;
    logic [NR*32-1:0]  gprs;
    logic              commit_valid, dt_ready, halted;
    logic [63:0]       commit_count;

    gpr_file #(.NR_REGS(NR), .RESET_PC(32'h8000_0000)) dut (
        .clk(clk), .resetn(resetn),
        .rs1_addr(rs1_addr), .rs1_data(rs1_data),
        .rs2_addr(rs2_addr), .rs2_data(rs2_data),
        .wb_valid(wb_valid), .wb_ready(wb_ready), .wb_wen(wb_wen),
        .wb_rd(wb_rd), .wb_data(wb_data), .wb_npc(wb_npc), .wb_halt(wb_halt),
        .gprs(gprs), .npc(npc), .commit_valid(commit_valid),
        .dt_ready(dt_ready), .commit_count(commit_count), .halted(halted)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    logic chk_en = 1'b0;

    // Behavioural model of the architectural state
    logic [31:0] m_regs [NR];
    logic [31:0] m_npc;
    logic [63:0] m_cnt;
    logic        m_cv;
    logic        m_halt;

    task automatic cmp(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic m_ready();
        return !m_halt && (!m_cv || dt_ready);
    endfunction

    function automatic logic [31:0] m_read(input logic [AW-1:0] a);
        if (a == 4'd0) return 32'h0;
        if (wb_valid && m_ready() && wb_wen && wb_rd == a) return wb_data;
        return m_regs[a];
    endfunction

    // Model update on each rising edge
    always @(posedge clk) begin
        if (!resetn) begin
            for (int i = 0; i < NR; i++) m_regs[i] = 32'h0;
            m_npc = 32'h8000_0000; m_cnt = 64'd0; m_cv = 1'b0; m_halt = 1'b0;
        end else if (wb_valid && m_ready()) begin
            if (wb_wen && wb_rd != 4'd0) m_regs[wb_rd] = wb_data;
            m_npc = wb_npc;
            m_cnt = m_cnt + 64'd1;
            m_cv  = 1'b1;
            if (wb_halt) m_halt = 1'b1;
        end else begin
            m_cv = m_cv && !dt_ready;
        end
    end

    // Compare process: every cycle, after inputs have settled
    always @(negedge clk) begin
        if (chk_en) begin
            logic [NR*32-1:0] eg;
            #2;
            for (int i = 0; i < NR; i++) eg[32*i +: 32] = m_regs[i];
            total++;
            if (gprs !== eg) begin
                bad++;
                $display("FAIL gprs: got %h expected %h at %0t", gprs, eg, $time);
            end
            cmp("npc", {32'h0, npc}, {32'h0, m_npc});
            cmp("commit_count", commit_count, m_cnt);
            cmp("commit_valid", {63'h0, commit_valid}, {63'h0, m_cv});
            cmp("halted", {63'h0, halted}, {63'h0, m_halt});
            cmp("wb_ready", {63'h0, wb_ready}, {63'h0, m_ready()});
            cmp("rs1_data", {32'h0, rs1_data}, {32'h0, m_read(rs1_addr)});
            cmp("rs2_data", {32'h0, rs2_data}, {32'h0, m_read(rs2_addr)});
        end
    end

    task automatic drive(input logic rst, input logic v, input logic wen,
                         input logic [AW-1:0] rd, input logic [31:0] d,
                         input logic [31:0] n, input logic h, input logic dt,
                         input logic [AW-1:0] a1, input logic [AW-1:0] a2);
        @(negedge clk);
        resetn = rst; wb_valid = v; wb_wen = wen; wb_rd = rd; wb_data = d;
        wb_npc = n; wb_halt = h; dt_ready = dt; rs1_addr = a1; rs2_addr = a2;
    endtask

    task automatic idle(input logic dt, input logic [AW-1:0] a1);
        drive(1'b1, 1'b0, 1'b0, 4'd0, 32'h0, 32'h0, 1'b0, dt, a1, 4'd0);
    endtask

    task automatic rand_cycles(input int n, input bit allow_halt);
        for (int k = 0; k < n; k++) begin
            drive(1'b1, ($urandom_range(3, 0) != 0), $urandom_range(1, 0),
                  AW'($urandom_range(NR - 1, 0)), $urandom, $urandom,
                  allow_halt && ($urandom_range(63, 0) == 0),
                  $urandom_range(1, 0),
                  AW'($urandom_range(NR - 1, 0)), AW'($urandom_range(NR - 1, 0)));
        end
    endtask

    initial begin
        resetn = 1'b0; wb_valid = 1'b0; wb_wen = 1'b0; wb_rd = '0; wb_data = '0;
        wb_npc = '0; wb_halt = 1'b0; dt_ready = 1'b0; rs1_addr = '0; rs2_addr = '0;
        drive(1'b0, 1'b0, 1'b0, 4'd0, 32'h0, 32'h0, 1'b0, 1'b0, 4'd0, 4'd0);
        chk_en = 1'b1;
        drive(1'b0, 1'b0, 1'b0, 4'd0, 32'h0, 32'h0, 1'b0, 1'b0, 4'd0, 4'd0);

        // Reset then idle
        idle(1'b1, 4'd5);
        #3;
        cmp("pin_rst_npc", {32'h0, npc}, 64'h0000_0000_8000_0000);
        cmp("pin_rst_cv", {63'h0, commit_valid}, 64'd0);
        cmp("pin_rst_cnt", commit_count, 64'd0);
        cmp("pin_rst_ready", {63'h0, wb_ready}, 64'd1);
        cmp("pin_rst_rs1", {32'h0, rs1_data}, 64'd0);
        cmp("pin_rst_gprs_lo", gprs[63:0], 64'd0);

        // Write with bypass
        drive(1'b1, 1'b1, 1'b1, 4'd3, 32'hDEAD_BEEF, 32'h8000_0004, 1'b0, 1'b1, 4'd3, 4'd0);
        #3;
        cmp("pin_bypass", {32'h0, rs1_data}, 64'h0000_0000_DEAD_BEEF);
        idle(1'b0, 4'd3);
        #3;
        cmp("pin_wr_gpr3", {32'h0, gprs[127:96]}, 64'h0000_0000_DEAD_BEEF);
        cmp("pin_wr_npc", {32'h0, npc}, 64'h0000_0000_8000_0004);
        cmp("pin_wr_cv", {63'h0, commit_valid}, 64'd1);
        cmp("pin_wr_cnt", commit_count, 64'd1);

        // Write to x0
        drive(1'b1, 1'b1, 1'b1, 4'd0, 32'h0000_1234, 32'h8000_0008, 1'b0, 1'b1, 4'd0, 4'd3);
        #3;
        cmp("pin_x0_rd", {32'h0, rs1_data}, 64'd0);
        idle(1'b1, 4'd0);
        #3;
        cmp("pin_x0_gpr0", {32'h0, gprs[31:0]}, 64'd0);
        cmp("pin_x0_cnt", commit_count, 64'd2);

        // Back-pressure
        idle(1'b1, 4'd0);
        drive(1'b1, 1'b1, 1'b1, 4'd7, 32'h0000_0077, 32'h8000_000C, 1'b0, 1'b0, 4'd7, 4'd0);
        for (int k = 0; k < 3; k++) begin
            drive(1'b1, 1'b1, 1'b1, 4'd8, 32'h0000_0088, 32'h8000_0010, 1'b0, 1'b0, 4'd8, 4'd7);
            #3;
            cmp("pin_bp_ready", {63'h0, wb_ready}, 64'd0);
            cmp("pin_bp_cv", {63'h0, commit_valid}, 64'd1);
        end
        drive(1'b1, 1'b1, 1'b1, 4'd8, 32'h0000_0088, 32'h8000_0010, 1'b0, 1'b1, 4'd8, 4'd7);
        #3;
        cmp("pin_bp_release", {63'h0, wb_ready}, 64'd1);
        idle(1'b0, 4'd0);
        #3;
        cmp("pin_bp_cv2", {63'h0, commit_valid}, 64'd1);
        cmp("pin_bp_cnt", commit_count, 64'd4);

        rand_cycles(400, 1'b0);

        // Halt
        idle(1'b1, 4'd0);
        drive(1'b1, 1'b1, 1'b0, 4'd0, 32'h0, 32'h8000_0010, 1'b1, 1'b0, 4'd0, 4'd0);
        idle(1'b0, 4'd0);
        #3;
        cmp("pin_halt", {63'h0, halted}, 64'd1);
        cmp("pin_halt_npc", {32'h0, npc}, 64'h0000_0000_8000_0010);
        cmp("pin_halt_cv", {63'h0, commit_valid}, 64'd1);
        for (int k = 0; k < 10; k++) begin
            drive(1'b1, 1'b1, 1'b1, AW'(k), 32'h0, 32'h0, 1'b0, k[0], AW'(k), AW'(k + 1));
            #3;
            cmp("pin_halt_ready", {63'h0, wb_ready}, 64'd0);
        end

        // Reset mid-commit
        drive(1'b0, 1'b0, 1'b0, 4'd0, 32'h0, 32'h0, 1'b0, 1'b0, 4'd0, 4'd0);
        drive(1'b1, 1'b1, 1'b1, 4'd2, 32'h0000_5555, 32'h8000_0100, 1'b0, 1'b0, 4'd2, 4'd0);
        idle(1'b0, 4'd2);
        #3;
        cmp("pin_mid_cv", {63'h0, commit_valid}, 64'd1);
        drive(1'b0, 1'b1, 1'b1, 4'd4, 32'h0000_6666, 32'h8000_0200, 1'b0, 1'b0, 4'd0, 4'd0);
        idle(1'b0, 4'd2);
        #3;
        cmp("pin_mid_cv0", {63'h0, commit_valid}, 64'd0);
        cmp("pin_mid_cnt", commit_count, 64'd0);
        cmp("pin_mid_npc", {32'h0, npc}, 64'h0000_0000_8000_0000);
        cmp("pin_mid_halted", {63'h0, halted}, 64'd0);
        cmp("pin_mid_ready", {63'h0, wb_ready}, 64'd1);
        cmp("pin_mid_gpr2", {32'h0, gprs[95:64]}, 64'd0);
        cmp("pin_mid_gpr4", {32'h0, gprs[159:128]}, 64'd0);

        rand_cycles(300, 1'b1);

        @(negedge clk);
        #4;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
